// File: rtl/config_pkg.sv
// Shared configuration for the UART transmit path and its upstream byte FIFO:
// bit timing, the byte type exchanged with the FIFO, and the transmitter states.
package config_pkg;

    // Default number of clk_i cycles per serial bit (must be >= 2).
    localparam int ClksPerBit = 4;

    // Byte type shared between the FIFO read port and the transmitter.
    typedef logic [7:0] ByteT;

    // Transmitter state register type and its encodings.
    typedef logic [1:0] UartStateT;

    localparam UartStateT UART_IDLE  = 2'd0;
    localparam UartStateT UART_START = 2'd1;
    localparam UartStateT UART_DATA  = 2'd2;
    localparam UartStateT UART_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer for the UART transmitter. Counts clk_i cycles within one
// serial bit and flags the last cycle of the bit with o_tick. i_restart forces
// the count back to zero so a new frame starts on a clean bit boundary.
module uart_baud_gen #(
    parameter int ClksPerBit = config_pkg::ClksPerBit
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;

    assign o_tick = (r_cnt == CntMax);

    // Next count: zero on restart or at the bit boundary, otherwise advance.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_restart || o_tick) begin
            w_cnt_nxt = {CntW{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + CntW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {CntW{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a byte FIFO. A byte is popped with a one-cycle
// ack strobe and serialised as start bit, 8 data bits LSB first, stop bit.
// A waiting byte is accepted in the last stop-bit cycle so consecutive frames
// follow with no idle gap. tx and busy are registered; rd_data only reaches
// the shift register, never tx or ack combinationally.
module uart_tx
    import config_pkg::*;
#(
    parameter int ClksPerBit = config_pkg::ClksPerBit
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rd_valid,
    input  ByteT rd_data,
    output logic ack,
    output logic tx,
    output logic busy
);

    UartStateT  r_state;
    ByteT       r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_tx;
    logic       r_busy;

    UartStateT  w_state_nxt;
    ByteT       w_shift_nxt;
    logic [2:0] w_bit_nxt;
    logic       w_tx_nxt;
    logic       w_tick;
    logic       w_restart;
    logic       w_ack;

    // A new byte is taken when idle, or in the final stop-bit cycle; never in reset.
    assign w_ack = ~reset_i & rd_valid &
                   ((r_state == UART_IDLE) | ((r_state == UART_STOP) & w_tick));

    // Hold the bit timer at zero while idle and realign it whenever a frame starts.
    assign w_restart = w_ack | (r_state == UART_IDLE);

    assign ack  = w_ack;
    assign tx   = r_tx;
    assign busy = r_busy;

    uart_baud_gen #(
        .ClksPerBit (ClksPerBit)
    ) u_baud_gen (
        .i_clk     (clk_i),
        .i_reset   (reset_i),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Frame sequencing: next state, shift register, bit index and line level.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_tx_nxt    = r_tx;
        if (w_ack) begin
            w_state_nxt = UART_START;
            w_shift_nxt = rd_data;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b0;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    w_tx_nxt = 1'b1;
                end
                UART_START: begin
                    if (w_tick) begin
                        w_state_nxt = UART_DATA;
                        w_bit_nxt   = 3'd0;
                        w_tx_nxt    = r_shift[0];
                    end else begin
                        w_tx_nxt    = 1'b0;
                    end
                end
                UART_DATA: begin
                    if (w_tick) begin
                        w_shift_nxt = r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = UART_STOP;
                            w_tx_nxt    = 1'b1;
                        end else begin
                            w_bit_nxt   = r_bit_cnt + 3'd1;
                            w_tx_nxt    = r_shift[1];
                        end
                    end else begin
                        w_tx_nxt    = r_shift[0];
                    end
                end
                UART_STOP: begin
                    if (w_tick) begin
                        w_state_nxt = UART_IDLE;
                    end else begin
                        w_state_nxt = UART_STOP;
                    end
                    w_tx_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = UART_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= UART_IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != UART_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A byte queue plays the FIFO; a frame-level
// model (frame position counter, bit index = position / ClksPerBit) predicts
// ack, tx and busy every cycle. Directed scenarios plus randomised traffic.
module tb_uart_tx;
    import config_pkg::*;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic       clk      = 1'b0;
    logic       reset_i  = 1'b1;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data  = 8'h00;
    logic       ack;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx #(.ClksPerBit(C)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ack      (ack),
        .tx       (tx),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit         drv_rst = 1'b1;
    bit         drv_en  = 1'b1;
    logic [7:0] fifo_q[$];

    // Frame-level reference model.
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;

    int obs_acks = 0;
    int obs_busy = 0;

    // Line level for frame bit slot idx: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        logic e_ack;
        logic e_tx;
        logic e_busy;
        @(negedge clk);
        reset_i  = drv_rst;
        rd_valid = drv_en && (fifo_q.size() > 0);
        rd_data  = rd_valid ? fifo_q[0] : 8'($urandom);
        #1;
        e_ack  = !reset_i && rd_valid && (!m_active || m_pos == FRAME - 1);
        e_tx   = m_active ? frame_bit(m_byte, m_pos / C) : 1'b1;
        e_busy = m_active;
        check_eq("ack", {31'd0, ack}, {31'd0, e_ack});
        check_eq("tx", {31'd0, tx}, {31'd0, e_tx});
        check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
        if (ack === 1'b1) obs_acks++;
        if (busy === 1'b1) obs_busy++;
        @(posedge clk);
        if (reset_i) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (e_ack) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_byte   = rd_data;
            void'(fifo_q.pop_front());
        end else if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_active = 1'b0;
                m_pos    = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        obs_acks = 0;
        obs_busy = 0;
    endtask

    // Step until the model is inside frame slot idx at offset off, bounded.
    task automatic run_until_slot(input int idx, input int off, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (m_active && m_pos == idx * C + off) hit = 1'b1;
            else step();
        end
        if (!hit) check_eq("slot_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset held for two cycles with nothing queued, then a long idle line.
        drv_rst = 1'b1;
        run(2);
        drv_rst = 1'b0;
        clear_counts();
        run(100);
        check_eq("idle_acks", obs_acks, 0);
        check_eq("idle_busy", obs_busy, 0);

        // Single byte 0x13: one ack, 40-cycle busy window.
        clear_counts();
        fifo_q.push_back(8'h13);
        run(50);
        check_eq("b13_acks", obs_acks, 1);
        check_eq("b13_busy", obs_busy, FRAME);

        // Back-to-back 0x00, 0x37: no gap, 80 busy cycles.
        clear_counts();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h37);
        run(90);
        check_eq("b2b_acks", obs_acks, 2);
        check_eq("b2b_busy", obs_busy, 2 * FRAME);

        // 0xDE for LSB-first order.
        clear_counts();
        fifo_q.push_back(8'hDE);
        run(50);
        check_eq("bDE_acks", obs_acks, 1);
        check_eq("bDE_busy", obs_busy, FRAME);

        // Reset inside data bit 3 of 0x37, with another byte already waiting.
        fifo_q.push_back(8'h37);
        run_until_slot(4, 1, 60);
        fifo_q.push_back(8'hA5);
        clear_counts();
        drv_rst = 1'b1;
        run(1);
        drv_rst = 1'b0;
        check_eq("rst_acks", obs_acks, 0);
        clear_counts();
        run(50);
        check_eq("post_rst_acks", obs_acks, 1);
        check_eq("post_rst_busy", obs_busy, FRAME);

        // rd_valid dropped mid-frame: frame finishes, second byte is held back.
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h81);
        run_until_slot(2, 0, 20);
        drv_en = 1'b0;
        clear_counts();
        run(60);
        check_eq("drop_acks", obs_acks, 0);
        check_eq("drop_busy", obs_busy, FRAME - 2 * C);
        drv_en = 1'b1;
        clear_counts();
        run(50);
        check_eq("resume_acks", obs_acks, 1);

        // Randomised traffic with sporadic valid drops and resets.
        for (int r = 0; r < 40; r++) begin
            int nb;
            int nc;
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) fifo_q.push_back(8'($urandom));
            nc = $urandom_range(20, 100);
            for (int k = 0; k < nc; k++) begin
                drv_en  = ($urandom_range(0, 9) != 0);
                drv_rst = ($urandom_range(0, 49) == 0);
                step();
            end
        end
        drv_en  = 1'b1;
        drv_rst = 1'b0;
        begin
            int budget;
            budget = 4000;
            while ((fifo_q.size() > 0 || m_active) && budget > 0) begin
                step();
                budget--;
            end
            if (budget == 0) check_eq("drain_timeout", 32'd0, 32'd1);
        end
        clear_counts();
        run(10);
        check_eq("final_idle_busy", obs_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
